// File: rtl/rf_write_arbiter_pkg.sv
// Shared register-file constants and the round-robin pointer helper.
package rf_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // Index following ptr in a ring of n requesters.
  function automatic logic [2:0] rr_next(input logic [2:0] ptr, input int unsigned n);
    if (32'(ptr) + 32'd1 >= n) return 3'd0;
    else return ptr + 3'd1;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid request at or after ptr_i.
module rr_pick #(
  parameter int unsigned NREQ = 3
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [2:0]      ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [2:0]      idx_o,
  output logic            any_o
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  int unsigned     pos;
  logic [PW-1:0]   sel;

  // Scan ptr, ptr+1, ... modulo NREQ and keep the first hit.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = 0;
    sel   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = (32'(ptr_i) + k) % NREQ;
      sel = PW'(pos);
      if (!any_o && req_i[sel]) begin
        any_o      = 1'b1;
        gnt_o[sel] = 1'b1;
        idx_o      = 3'(pos);
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ
// writeback requesters; drives registered write-port signals and counters.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned DATA_W = REG_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   RFwenable,
  output logic [ADDR_W-1:0]      RFdestination_register,
  output logic [DATA_W-1:0]      RFwrite_data,
  output logic [2:0]             grant_id,
  output logic [31:0]            wr_count,
  output logic [7:0]             drop_count
);

  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [2:0]        gid_q, gid_d;
  logic [31:0]       wr_q, wr_d;
  logic [7:0]        drop_q, drop_d;

  logic [NREQ-1:0]   pick_gnt;
  logic [2:0]        pick_idx;
  logic              pick_any;
  logic              grant;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign grant     = pick_any && !stall && !rst;
  assign req_ready = grant ? pick_gnt : '0;

  // Select the winning requester's address and data from the packed buses.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next state: latch the winner on a grant; register-0 writes are accepted
  // but never enabled, and only bump the saturating drop counter.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wen_d    = 1'b0;
    dest_d   = dest_q;
    data_d   = data_q;
    gid_d    = gid_q;
    wr_d     = wr_q;
    drop_d   = drop_q;
    if (grant) begin
      dest_d   = win_addr;
      data_d   = win_data;
      gid_d    = pick_idx;
      rr_ptr_d = rr_next(pick_idx, NREQ);
      if (win_addr != '0) begin
        wen_d = 1'b1;
        wr_d  = wr_q + 32'd1;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      wen_q    <= 1'b0;
      dest_q   <= '0;
      data_q   <= '0;
      gid_q    <= '0;
      wr_q     <= '0;
      drop_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wen_q    <= wen_d;
      dest_q   <= dest_d;
      data_q   <= data_d;
      gid_q    <= gid_d;
      wr_q     <= wr_d;
      drop_q   <= drop_d;
    end
  end

  assign RFwenable              = wen_q;
  assign RFdestination_register = dest_q;
  assign RFwrite_data           = data_q;
  assign grant_id               = gid_q;
  assign wr_count               = wr_q;
  assign drop_count             = drop_q;

endmodule
